// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage MIPS32-subset core with internal
// register file and unified word-addressed memory.
package pipe_mips32_pkg;
  typedef enum logic [2:0] {
    K_NOP, K_RR, K_RI, K_LW, K_SW, K_BR, K_HLT
  } kind_t;

  typedef struct packed {
    logic        v;
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    kind_t       kind;
    logic [5:0]  op;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        wr;
  } id_ex_t;

  typedef struct packed {
    kind_t       kind;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wr;
    logic        cond;
  } ex_mem_t;

  typedef struct packed {
    kind_t       kind;
    logic [31:0] val;
    logic [4:0]  dst;
    logic        wr;
  } mem_wb_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;
endpackage

module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  if_id_t  ifid;
  id_ex_t  idex, id_nx;
  ex_mem_t exmem, ex_nx;
  mem_wb_t memwb, mem_nx;

  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] fa, fb;
  logic        wb_we;
  logic        stop;

  assign id_rs  = ifid.ir[25:21];
  assign id_rt  = ifid.ir[20:16];
  assign id_rd  = ifid.ir[15:11];
  assign wb_we  = memwb.wr && !HALTED;
  assign halted = HALTED;

  assign TAKEN_BRANCH = (exmem.kind == K_BR)
                     && exmem.cond && !HALTED;

  // fetch holds while a HLT is anywhere from ID onward
  assign stop = (id_nx.kind == K_HLT)
             || (idex.kind == K_HLT)
             || (exmem.kind == K_HLT)
             || (memwb.kind == K_HLT);

  // decode and register read, same-cycle WB bypassed
  always_comb begin
    id_nx     = '0;
    id_nx.op  = ifid.ir[31:26];
    id_nx.rs  = id_rs;
    id_nx.rt  = id_rt;
    id_nx.npc = ifid.npc;
    id_nx.imm = {{16{ifid.ir[15]}}, ifid.ir[15:0]};
    id_nx.a   = (wb_we && memwb.dst == id_rs)
              ? memwb.val : Reg[id_rs];
    id_nx.b   = (wb_we && memwb.dst == id_rt)
              ? memwb.val : Reg[id_rt];
    if (ifid.v) begin
      case (ifid.ir[31:26])
        OP_ADD, OP_SUB, OP_AND,
        OP_OR, OP_SLT, OP_MUL:  id_nx.kind = K_RR;
        OP_ADDI, OP_SUBI,
        OP_SLTI:                id_nx.kind = K_RI;
        OP_LW:                  id_nx.kind = K_LW;
        OP_SW:                  id_nx.kind = K_SW;
        OP_BNEQZ, OP_BEQZ:      id_nx.kind = K_BR;
        OP_HLT:                 id_nx.kind = K_HLT;
        default:                id_nx.kind = K_NOP;
      endcase
    end
    id_nx.dst = (id_nx.kind == K_RR) ? id_rd : id_rt;
    id_nx.wr  = ((id_nx.kind == K_RR)
              || (id_nx.kind == K_RI)
              || (id_nx.kind == K_LW))
              && (id_nx.dst != 5'd0);
  end

  // execute with forwarding; EX/MEM (younger) wins over MEM/WB
  always_comb begin
    fa = idex.a;
    fb = idex.b;
    if (memwb.wr && memwb.dst == idex.rs) fa = memwb.val;
    if (memwb.wr && memwb.dst == idex.rt) fb = memwb.val;
    if (exmem.wr && exmem.kind != K_LW
        && exmem.dst == idex.rs) fa = exmem.alu;
    if (exmem.wr && exmem.kind != K_LW
        && exmem.dst == idex.rt) fb = exmem.alu;
    ex_nx      = '0;
    ex_nx.kind = idex.kind;
    ex_nx.dst  = idex.dst;
    ex_nx.wr   = idex.wr;
    ex_nx.b    = fb;
    case (idex.kind)
      K_RR: begin
        case (idex.op)
          OP_SUB:  ex_nx.alu = fa - fb;
          OP_AND:  ex_nx.alu = fa & fb;
          OP_OR:   ex_nx.alu = fa | fb;
          OP_SLT:  ex_nx.alu =
                     {31'b0, $signed(fa) < $signed(fb)};
          OP_MUL:  ex_nx.alu = fa * fb;
          default: ex_nx.alu = fa + fb;
        endcase
      end
      K_RI: begin
        case (idex.op)
          OP_SUBI: ex_nx.alu = fa - idex.imm;
          OP_SLTI: ex_nx.alu =
                     {31'b0, $signed(fa) < $signed(idex.imm)};
          default: ex_nx.alu = fa + idex.imm;
        endcase
      end
      K_LW, K_SW: ex_nx.alu = fa + idex.imm;
      K_BR: begin
        ex_nx.alu  = idex.npc + idex.imm;
        ex_nx.cond = (idex.op == OP_BEQZ)
                   ? (fa == 32'd0) : (fa != 32'd0);
      end
      default: ;
    endcase
  end

  // memory stage: load data or pass ALU result through
  always_comb begin
    mem_nx      = '0;
    mem_nx.kind = exmem.kind;
    mem_nx.dst  = exmem.dst;
    mem_nx.wr   = exmem.wr;
    mem_nx.val  = (exmem.kind == K_LW)
                ? Mem[exmem.alu[AW-1:0]] : exmem.alu;
  end

  // pipeline advance; a taken branch squashes IF/ID and ID/EX
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC     <= '0;
      HALTED <= 1'b0;
      ifid   <= '0;
      idex   <= '0;
      exmem  <= '0;
      memwb  <= '0;
    end else if (!HALTED) begin
      memwb <= mem_nx;
      if (memwb.kind == K_HLT) HALTED <= 1'b1;
      if (TAKEN_BRANCH) begin
        ifid  <= '{v: 1'b1,
                   ir: Mem[exmem.alu[AW-1:0]],
                   npc: exmem.alu + 32'd1};
        PC    <= exmem.alu + 32'd1;
        idex  <= '0;
        exmem <= '0;
      end else begin
        idex  <= id_nx;
        exmem <= ex_nx;
        if (stop) begin
          ifid <= '0;
        end else begin
          ifid <= '{v: 1'b1,
                    ir: Mem[PC[AW-1:0]],
                    npc: PC + 32'd1};
          PC   <= PC + 32'd1;
        end
      end
    end
  end

  // architectural writes; arrays are left unreset for preloading
  always @(posedge clk1) begin
    if (rst_n && !HALTED && exmem.kind == K_SW)
      Mem[exmem.alu[AW-1:0]] <= exmem.b;
    if (rst_n && wb_we)
      Reg[memwb.dst] <= memwb.val;
  end
endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: directed vectors, corner sequences and random
// programs compared against an instruction-level reference model.
module tb_pipe_mips32;
  logic clk1 = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .halted(halted)
  );

  always #5 clk1 = ~clk1;

  localparam logic [31:0] NOPW = 32'hf800_0000;
  localparam logic [31:0] HLTW = 32'hfc00_0000;
  localparam logic [31:0] ORW  = 32'h0ce7_7800;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  logic [31:0] mr [0:31];
  logic [31:0] mm [0:1023];

  typedef struct {
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    int          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [14];

  function automatic logic [31:0] rr(input int o, input int s,
                                     input int t, input int d);
    return {o[5:0], s[4:0], t[4:0], d[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] ri(input int o, input int s,
                                     input int t, input int im);
    return {o[5:0], s[4:0], t[4:0], im[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    @(negedge clk1);
  endtask

  task automatic preload_default();
    for (int i = 0; i < 1024; i++) dut.Mem[i] = NOPW;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
  endtask

  task automatic run(input int budget, output int cyc);
    pulses = 0;
    cyc = 0;
    @(negedge clk1);
    rst_n = 1'b1;
    while (cyc < budget && !halted) begin
      @(negedge clk1);
      cyc++;
      if (dut.TAKEN_BRANCH) pulses++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  // sequential instruction-set interpreter over mr/mm
  task automatic model(output logic [31:0] pc_f);
    logic [31:0] pc, ir, a, b, imm, ad;
    logic [4:0]  rs, rt, rd;
    bit          done;
    pc = 0;
    done = 0;
    for (int s = 0; s < 4000 && !done; s++) begin
      ir = mm[pc[9:0]];
      pc = pc + 1;
      rs = ir[25:21];
      rt = ir[20:16];
      rd = ir[15:11];
      imm = {{16{ir[15]}}, ir[15:0]};
      a = mr[rs];
      b = mr[rt];
      ad = a + imm;
      case (ir[31:26])
        6'd0:  if (rd != 0) mr[rd] = a + b;
        6'd1:  if (rd != 0) mr[rd] = a - b;
        6'd2:  if (rd != 0) mr[rd] = a & b;
        6'd3:  if (rd != 0) mr[rd] = a | b;
        6'd4:  if (rd != 0)
                 mr[rd] = ($signed(a) < $signed(b)) ? 1 : 0;
        6'd5:  if (rd != 0) mr[rd] = a * b;
        6'd10: if (rt != 0) mr[rt] = a + imm;
        6'd11: if (rt != 0) mr[rt] = a - imm;
        6'd12: if (rt != 0)
                 mr[rt] = ($signed(a) < $signed(imm)) ? 1 : 0;
        6'd8:  if (rt != 0) mr[rt] = mm[ad[9:0]];
        6'd9:  mm[ad[9:0]] = b;
        6'd13: if (a != 0) pc = pc + imm;
        6'd14: if (a == 0) pc = pc + imm;
        6'd63: done = 1;
        default: ;
      endcase
    end
    pc_f = pc;
  endtask

  task automatic rand_test(input int t);
    int i, k, n, cyc;
    logic [31:0] pcf;
    n = 40;
    for (int j = 0; j < 1024; j++) mm[j] = NOPW;
    i = 0;
    while (i < n) begin
      k = $urandom_range(0, 9);
      if (k <= 4) begin
        mm[i] = rr($urandom_range(0, 5), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 30));
      end else if (k <= 6) begin
        mm[i] = ri($urandom_range(10, 12), $urandom_range(0, 31),
                   $urandom_range(0, 30), $urandom_range(0, 65535));
      end else if (k == 7) begin
        mm[i] = ri(8, 31, $urandom_range(0, 30),
                   $urandom_range(0, 31));
        if (i + 1 < n) begin
          i++;
          mm[i] = NOPW;
        end
      end else if (k == 8) begin
        mm[i] = ri(9, 31, $urandom_range(0, 31),
                   $urandom_range(0, 31));
      end else begin
        mm[i] = ri($urandom_range(13, 14),
                   ($urandom_range(0, 3) == 0)
                     ? 0 : $urandom_range(1, 30),
                   0,
                   $urandom_range(0, (n - 1 - i < 3) ? n - 1 - i : 3));
      end
      i++;
    end
    mm[n] = HLTW;
    for (int j = 512; j < 544; j++) mm[j] = $urandom;
    mr[0] = 0;
    for (int r = 1; r < 31; r++)
      mr[r] = ($urandom_range(0, 3) == 0)
            ? 32'($urandom_range(0, 2)) : $urandom;
    mr[31] = 32'd512;
    enter_reset();
    for (int j = 0; j < 1024; j++) dut.Mem[j] = mm[j];
    for (int r = 0; r < 32; r++) dut.Reg[r] = mr[r];
    model(pcf);
    run(400, cyc);
    for (int r = 0; r < 32; r++)
      chk($sformatf("rnd%0d_reg%0d", t, r), dut.Reg[r], mr[r]);
    for (int j = 512; j < 544; j++)
      chk($sformatf("rnd%0d_mem%0d", t, j), dut.Mem[j], mm[j]);
    chk($sformatf("rnd%0d_pc", t), dut.PC, pcf);
  endtask

  initial begin
    int cyc;
    vt[0]  = '{rr(0, 1, 2, 3), 32'h7fffffff, 32'h1, 3, 32'h80000000};
    vt[1]  = '{rr(1, 1, 2, 3), 32'd5, 32'd7, 3, 32'hfffffffe};
    vt[2]  = '{rr(2, 1, 2, 3), 32'hf0f0ff00, 32'h0ff00ff0, 3,
               32'h00f00f00};
    vt[3]  = '{rr(3, 1, 2, 3), 32'hf0f00000, 32'h00000f0f, 3,
               32'hf0f00f0f};
    vt[4]  = '{rr(4, 1, 2, 3), 32'hffffffff, 32'd1, 3, 32'd1};
    vt[5]  = '{rr(4, 1, 2, 3), 32'd1, 32'hffffffff, 3, 32'd0};
    vt[6]  = '{rr(5, 1, 2, 3), 32'h00010000, 32'h00010003, 3,
               32'h00030000};
    vt[7]  = '{rr(5, 1, 2, 3), 32'd7, 32'hfffffffd, 3, 32'hffffffeb};
    vt[8]  = '{ri(10, 1, 3, -3), 32'd10, 32'd0, 3, 32'd7};
    vt[9]  = '{ri(11, 1, 3, 1), 32'd0, 32'd0, 3, 32'hffffffff};
    vt[10] = '{ri(12, 1, 3, -4), 32'hfffffffb, 32'd0, 3, 32'd1};
    vt[11] = '{ri(12, 1, 3, 3), 32'd3, 32'd0, 3, 32'd0};
    vt[12] = '{rr(62, 1, 2, 3), 32'd1, 32'd2, 3, 32'h0000dead};
    vt[13] = '{rr(0, 1, 2, 0), 32'd5, 32'd6, 0, 32'd0};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_pc", dut.PC, 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
    @(negedge clk1);

    for (int i = 0; i < 14; i++) begin
      enter_reset();
      preload_default();
      dut.Reg[1] = vt[i].a;
      dut.Reg[2] = vt[i].b;
      dut.Reg[3] = 32'h0000dead;
      dut.Mem[0] = vt[i].ir;
      dut.Mem[1] = HLTW;
      run(30, cyc);
      chk($sformatf("vec%0d", i), dut.Reg[vt[i].chk], vt[i].exp);
    end

    enter_reset();
    preload_default();
    dut.Mem[0] = 32'h2801000a;
    dut.Mem[1] = 32'h28020014;
    dut.Mem[2] = 32'h28030019;
    dut.Mem[3] = ORW;
    dut.Mem[4] = ORW;
    dut.Mem[5] = 32'h00222000;
    dut.Mem[6] = ORW;
    dut.Mem[7] = 32'h00832800;
    dut.Mem[8] = HLTW;
    run(40, cyc);
    chk("main_cycles", 32'(cyc <= 20), 32'd1);
    chk("main_r1", dut.Reg[1], 32'd10);
    chk("main_r2", dut.Reg[2], 32'd20);
    chk("main_r3", dut.Reg[3], 32'd25);
    chk("main_r4", dut.Reg[4], 32'd30);
    chk("main_r5", dut.Reg[5], 32'd55);
    chk("main_pc", dut.PC, 32'd9);

    enter_reset();
    preload_default();
    dut.Mem[0] = ri(10, 0, 1, 5);
    dut.Mem[1] = rr(0, 1, 1, 2);
    dut.Mem[2] = HLTW;
    run(30, cyc);
    chk("b2b_r2", dut.Reg[2], 32'd10);

    enter_reset();
    preload_default();
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = ri(10, 0, 1, 120);
    dut.Mem[1] = ORW;
    dut.Mem[2] = ri(8, 1, 2, 0);
    dut.Mem[3] = ORW;
    dut.Mem[4] = ri(10, 2, 2, 45);
    dut.Mem[5] = ORW;
    dut.Mem[6] = ri(9, 1, 2, 1);
    dut.Mem[7] = HLTW;
    run(40, cyc);
    chk("ldst_mem121", dut.Mem[121], 32'd130);

    enter_reset();
    preload_default();
    dut.Mem[300] = 32'd85;
    dut.Mem[0] = ri(8, 0, 2, 300);
    dut.Mem[1] = rr(0, 2, 0, 3);
    dut.Mem[2] = rr(0, 2, 0, 4);
    dut.Mem[3] = HLTW;
    run(30, cyc);
    chk("loaduse_stale_r3", dut.Reg[3], 32'd2);
    chk("loaduse_fwd_r4", dut.Reg[4], 32'd85);

    enter_reset();
    preload_default();
    dut.Mem[0] = ri(14, 0, 0, 2);
    dut.Mem[1] = ri(10, 0, 9, 1);
    dut.Mem[2] = ri(10, 0, 9, 1);
    dut.Mem[3] = ri(10, 0, 10, 7);
    dut.Mem[4] = HLTW;
    run(30, cyc);
    chk("br_r9", dut.Reg[9], 32'd9);
    chk("br_r10", dut.Reg[10], 32'd7);
    chk("br_pulses", 32'(pulses), 32'd1);

    enter_reset();
    preload_default();
    dut.Mem[200] = 32'h1234;
    dut.Mem[0] = HLTW;
    dut.Mem[1] = ri(10, 0, 6, 99);
    dut.Mem[2] = ri(9, 0, 6, 200);
    run(30, cyc);
    chk("hlt_pc", dut.PC, 32'd1);
    repeat (5) @(negedge clk1);
    chk("hlt_pc_frozen", dut.PC, 32'd1);
    chk("hlt_r6", dut.Reg[6], 32'd6);
    chk("hlt_mem200", dut.Mem[200], 32'h1234);
    chk("hlt_still", 32'(halted), 32'd1);

    enter_reset();
    preload_default();
    dut.Mem[0] = 32'h2801000a;
    dut.Mem[1] = 32'h28020014;
    dut.Mem[2] = 32'h28030019;
    dut.Mem[3] = ORW;
    dut.Mem[4] = ORW;
    dut.Mem[5] = 32'h00222000;
    dut.Mem[6] = ORW;
    dut.Mem[7] = 32'h00832800;
    dut.Mem[8] = HLTW;
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", dut.PC, 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    repeat (3) @(negedge clk1);
    chk("midrst_r5_untouched", dut.Reg[5], 32'd5);
    chk("midrst_pc_held", dut.PC, 32'd0);
    run(40, cyc);
    chk("rerun_r4", dut.Reg[4], 32'd30);
    chk("rerun_r5", dut.Reg[5], 32'd55);

    for (int t = 0; t < 12; t++) rand_test(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
